// File: rtl/data_mem_axil_master_if.sv
// AXI4-Lite bus bundle used by the MEM-stage data master and its slave.
// All five channels are carried here; the 32-bit data path is fixed by the CPU word size.
interface data_mem_axil_master_if #(
   parameter int ADDR_WIDTH = 32
) ();
   // write address channel
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   // write data channel
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   // write response channel
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   // read address channel
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   // read data channel
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/data_mem_axil_master.sv
// AXI4-Lite master for CPU data loads/stores in the MEM stage.
// One access at a time: the pipeline is stalled from request until the response
// arrives, then released for exactly one cycle (DONE) so it advances once per access.
module data_mem_axil_master #(
   parameter int          ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  byte_select_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        bus_error_o,
   data_mem_axil_master_if.master m
);

   // The timer never exceeds TIMEOUT_CYCLES-1, so log2(TIMEOUT_CYCLES) bits suffice.
   localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
      TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_DONE
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic [31:0]             wdata_reg, wdata_next;
   logic [3:0]              wstrb_reg, wstrb_next;
   logic [31:0]             rdata_reg, rdata_next;
   logic                    awvalid_reg, awvalid_next;
   logic                    wvalid_reg, wvalid_next;
   logic                    aw_done_reg, aw_done_next;
   logic                    w_done_reg, w_done_next;
   logic                    bready_reg, bready_next;
   logic                    arvalid_reg, arvalid_next;
   logic                    rready_reg, rready_next;
   logic                    bus_error_reg, bus_error_next;
   logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;

   logic [ADDR_WIDTH-1:0]   addr_ext;
   logic                    timed_out;
   logic [TIMER_WIDTH-1:0]  timer_inc;
   logic                    aw_hs, w_hs, aw_fin, w_fin;
   logic                    unused_bits;

   // Word-align the byte address and fit it to the bus width (truncate or zero-extend).
   generate
      for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr
         if (gi >= 2 && gi < 32) begin : g_bit
            assign addr_ext[gi] = addr_i[gi];
         end else begin : g_zero
            assign addr_ext[gi] = 1'b0;
         end
      end
   endgenerate

   // Byte offset and the low response bits carry no information for this master.
   assign unused_bits = ^{addr_i, m.bresp, m.rresp};

   assign timed_out = TIMEOUT_EN && (timer_reg == TIMER_LAST);
   assign timer_inc = TIMEOUT_EN ? timer_reg + 1'b1 : '0;
   assign aw_hs     = awvalid_reg & m.awready;
   assign w_hs      = wvalid_reg & m.wready;
   assign aw_fin    = aw_done_reg | aw_hs;
   assign w_fin     = w_done_reg | w_hs;

   // State and payload registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         rdata_reg     <= '0;
         awvalid_reg   <= 1'b0;
         wvalid_reg    <= 1'b0;
         aw_done_reg   <= 1'b0;
         w_done_reg    <= 1'b0;
         bready_reg    <= 1'b0;
         arvalid_reg   <= 1'b0;
         rready_reg    <= 1'b0;
         bus_error_reg <= 1'b0;
         timer_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         wstrb_reg     <= wstrb_next;
         rdata_reg     <= rdata_next;
         awvalid_reg   <= awvalid_next;
         wvalid_reg    <= wvalid_next;
         aw_done_reg   <= aw_done_next;
         w_done_reg    <= w_done_next;
         bready_reg    <= bready_next;
         arvalid_reg   <= arvalid_next;
         rready_reg    <= rready_next;
         bus_error_reg <= bus_error_next;
         timer_reg     <= timer_next;
      end
   end

   // Next-state and handshake sequencing; error pulse is raised only for the DONE cycle.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      wstrb_next     = wstrb_reg;
      rdata_next     = rdata_reg;
      awvalid_next   = awvalid_reg;
      wvalid_next    = wvalid_reg;
      aw_done_next   = aw_done_reg;
      w_done_next    = w_done_reg;
      bready_next    = bready_reg;
      arvalid_next   = arvalid_reg;
      rready_next    = rready_reg;
      bus_error_next = 1'b0;
      timer_next     = timer_reg;

      case (state_reg)
         ST_IDLE: begin
            // A store has priority; a simultaneous load request is ignored.
            if (mem_write_i) begin
               addr_next    = addr_ext;
               wdata_next   = wdata_i;
               wstrb_next   = byte_select_i;
               awvalid_next = 1'b1;
               wvalid_next  = 1'b1;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               timer_next   = '0;
               state_next   = ST_WR;
            end else if (mem_read_i) begin
               addr_next    = addr_ext;
               arvalid_next = 1'b1;
               timer_next   = '0;
               state_next   = ST_RD_ADDR;
            end
         end

         ST_WR: begin
            timer_next   = timer_inc;
            awvalid_next = awvalid_reg & ~aw_hs;
            wvalid_next  = wvalid_reg & ~w_hs;
            aw_done_next = aw_fin;
            w_done_next  = w_fin;
            if (aw_fin && w_fin) begin
               bready_next = 1'b1;
               timer_next  = '0;
               state_next  = ST_WR_RESP;
            end else if (timed_out) begin
               awvalid_next   = 1'b0;
               wvalid_next    = 1'b0;
               bus_error_next = 1'b1;
               state_next     = ST_DONE;
            end
         end

         ST_WR_RESP: begin
            timer_next = timer_inc;
            if (m.bvalid && bready_reg) begin
               bready_next    = 1'b0;
               bus_error_next = m.bresp[1];
               state_next     = ST_DONE;
            end else if (timed_out) begin
               bready_next    = 1'b0;
               bus_error_next = 1'b1;
               state_next     = ST_DONE;
            end
         end

         ST_RD_ADDR: begin
            timer_next = timer_inc;
            if (arvalid_reg && m.arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               timer_next   = '0;
               state_next   = ST_RD_DATA;
            end else if (timed_out) begin
               arvalid_next   = 1'b0;
               bus_error_next = 1'b1;
               rdata_next     = TIMEOUT_RDATA;
               state_next     = ST_DONE;
            end
         end

         ST_RD_DATA: begin
            timer_next = timer_inc;
            if (m.rvalid && rready_reg) begin
               rdata_next     = m.rdata;
               rready_next    = 1'b0;
               bus_error_next = m.rresp[1];
               state_next     = ST_DONE;
            end else if (timed_out) begin
               rready_next    = 1'b0;
               bus_error_next = 1'b1;
               rdata_next     = TIMEOUT_RDATA;
               state_next     = ST_DONE;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Stall is combinational so the pipeline freezes in the same cycle the request appears.
   always_comb begin
      stall_o = 1'b0;
      case (state_reg)
         ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA: stall_o = 1'b1;
         ST_IDLE:                                   stall_o = mem_read_i | mem_write_i;
         default:                                   stall_o = 1'b0;
      endcase
   end

   assign rdata_o     = rdata_reg;
   assign bus_error_o = bus_error_reg;

   assign m.awaddr  = addr_reg;
   assign m.awprot  = 3'b000;
   assign m.awvalid = awvalid_reg;
   assign m.wdata   = wdata_reg;
   assign m.wstrb   = wstrb_reg;
   assign m.wvalid  = wvalid_reg;
   assign m.bready  = bready_reg;
   assign m.araddr  = addr_reg;
   assign m.arprot  = 3'b000;
   assign m.arvalid = arvalid_reg;
   assign m.rready  = rready_reg;

endmodule
